ram_port_a_arbiter: RTL and testbench
=====================================

# ram_port_a_arbiter

Two-requester arbiter that shares port A (read/write, byte-enabled, 1-cycle read latency) of a `ram_DxWb_rrw_p1p1` instance between requester 0 (CPU data bus) and requester 1 (debug/DMA master). Port B of the RAM is not touched by this block.

- Fairness: round-robin, with an optional lock for read-modify-write sequences and a bounded hold counter so neither side starves.
- Output: read data returns one cycle after grant, tagged to the requester that issued it.

## Interface
Parameters:
- DEPTH, 4096, RAM words; address width AW = $clog2(DEPTH).
- WIDTH, 32, data bits; must be a multiple of 8; BE = WIDTH/8.
- MAX_HOLD, 8, maximum consecutive grants to one requester while the other is waiting (1..255).

Ports (n = 0,1):
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- rn_valid  in  1  request valid.
- rn_ready  out  1  request accepted this cycle (grant).
- rn_addr  in  AW  word address.
- rn_wr  in  1  1 = write, 0 = read.
- rn_be  in  BE  byte enables, writes only.
- rn_wdata  in  WIDTH  write data.
- rn_lock  in  1  keep grant after this beat (RMW/burst).
- rn_rsp_valid  out  1  read data valid.
- rn_rsp_rdata  out  WIDTH  read data.
- ram_address_a  out  AW  to RAM.
- ram_wren_a  out  1  to RAM.
- ram_byteena_a  out  BE  to RAM.
- ram_data_a  out  WIDTH  to RAM.
- ram_q_a  in  WIDTH  from RAM, valid 1 cycle after a read address.

## Operation
State:
- prio: next preferred requester.
- owner: lock holder, or none.
- hold_cnt: consecutive grants to the current winner.
- rsp_owner_q, rsp_pend_q: response tracking.

Reset:
- prio=0, owner=none, hold_cnt=0, rsp_pend_q=0.
- While reset=1: rn_ready=0, ram_wren_a=0, rn_rsp_valid=0.

Grant (combinational, one grant per cycle):
- Owner set and owner valid: grant owner, unless the other side is valid and hold_cnt==MAX_HOLD. In that case the lock is broken: grant the other side, owner=none.
- Owner set and owner not valid: grant nothing; the lock holds the port idle.
- No owner, one requester valid: grant it.
- No owner, both valid: grant prio, unless prio's hold_cnt==MAX_HOLD, then grant the other.

RAM drive:
- ram_* are muxed from the granted requester.
- ram_wren_a = granted & rn_wr; ram_byteena_a = rn_be for writes, all-ones for reads.
- With no grant: ram_wren_a=0, address/data hold the last value (don't care).

After a grant to n:
- prio ← 1-n.
- hold_cnt ← (same winner as the previous grant) ? sat(hold_cnt+1) : 1.
- owner ← rn_lock ? n : none.

Lock release:
- rn_lock=0 on a granted beat releases the lock.
- rn_valid=0 while owner=n keeps the lock; hold_cnt does not advance.

Responses:
- A granted read sets rsp_pend_q=1, rsp_owner_q=n.
- The next cycle drives r[rsp_owner_q]_rsp_valid=1 with rsp_rdata=ram_q_a; the other side's rsp_valid=0.
- Writes produce no response.
- rsp_rdata is don't-care when rsp_valid=0.

Ordering:
- A read following a same-cycle-adjacent write to the same address returns the new data. The RAM is read-after-write ordered on a single port across cycles.

## Timing
- Request → grant: 0 cycles (combinational rn_ready from valid/state). Requesters hold addr/wr/be/wdata stable until ready.
- Read latency: grant at cycle T → rn_rsp_valid at T+1. Back-to-back reads give one response per cycle.
- Write: committed at the rising edge ending grant cycle T.
- Throughput: 1 access/cycle total. With both requesters continuously valid and unlocked, grants alternate 0,1,0,1.
- Lock starvation bound: the other requester waits at most MAX_HOLD cycles.
- Reset mid-operation: a read granted in the cycle before reset asserts gets no response (rsp_pend_q cleared). A lock is dropped.

## Test plan
- Reset:
  - Stimulus: assert reset 3 cycles with both rn_valid=1.
  - Required: r0_ready=r1_ready=0, ram_wren_a=0, no rsp_valid.
  - After release: first grant goes to r0.
- Alternation:
  - Stimulus: both valid, r0 reads addr 0x10..0x13, r1 reads 0x20..0x23, RAM preloaded with data=addr.
  - Required: grants r0,r1,r0,r1…; each rsp_valid one cycle after its grant, on the correct port, rdata=addr.
- Write then read:
  - Stimulus: r1 writes 0xDEADBEEF to 0x5 with be=4'b0101, then reads 0x5; prior content 0x11223344.
  - Required: r1 read returns 0x11AD33EF.
- Lock:
  - Stimulus: r0 issues read 0x7 with lock, then write 0x7 with lock=0, while r1 is continuously valid.
  - Required: r1 is not granted until the cycle after r0's write.
- Starvation bound:
  - Stimulus: MAX_HOLD=4, r0 holds lock with continuous valid, r1 valid.
  - Required: r1 granted on the 5th contended cycle; owner cleared.
- Idle lock and reset mid-read:
  - Stimulus: r0 locks then drops valid for 3 cycles.
  - Required: no grants to r1 during those 3 cycles.
  - Stimulus: assert reset the cycle after a read grant.
  - Required: no rsp_valid.

Source files
------------

// File: rtl/ram_port_a_arbiter.sv
// Round-robin arbiter sharing port A of a single-port-latency RAM between
// two requesters, with RMW lock, bounded hold and tagged read responses.
module ram_port_a_arbiter #(
    parameter int DEPTH    = 4096,
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int BE      = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [AW-1:0]    r0_addr,
    input  logic             r0_wr,
    input  logic [BE-1:0]    r0_be,
    input  logic [WIDTH-1:0] r0_wdata,
    input  logic             r0_lock,
    output logic             r0_rsp_valid,
    output logic [WIDTH-1:0] r0_rsp_rdata,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [AW-1:0]    r1_addr,
    input  logic             r1_wr,
    input  logic [BE-1:0]    r1_be,
    input  logic [WIDTH-1:0] r1_wdata,
    input  logic             r1_lock,
    output logic             r1_rsp_valid,
    output logic [WIDTH-1:0] r1_rsp_rdata,

    output logic [AW-1:0]    ram_address_a,
    output logic             ram_wren_a,
    output logic [BE-1:0]    ram_byteena_a,
    output logic [WIDTH-1:0] ram_data_a,
    input  logic [WIDTH-1:0] ram_q_a
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic             prio_q;
    logic             owner_vld_q;
    logic             owner_id_q;
    logic             last_win_q;
    logic [7:0]       hold_cnt_q;
    logic             vld_p1;
    logic             rsp_owner_p1;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;

    logic             gnt;
    logic             win;
    logic             hold_max;
    logic             own_valid;
    logic             oth_valid;
    logic             sel_wr;
    logic             sel_lock;
    logic [AW-1:0]    sel_addr;
    logic [BE-1:0]    sel_be;
    logic [WIDTH-1:0] sel_wdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= HOLD_MAX) ? HOLD_MAX : c + 8'd1;
    endfunction

    always_comb begin
        gnt       = 1'b0;
        win       = 1'b0;
        hold_max  = (hold_cnt_q == HOLD_MAX);
        own_valid = owner_id_q ? r1_valid : r0_valid;
        oth_valid = owner_id_q ? r0_valid : r1_valid;
        if (owner_vld_q) begin
            // A locked owner keeps the port (even idle) until the other side
            // has waited out the hold budget.
            if (own_valid) begin
                gnt = 1'b1;
                win = (oth_valid && hold_max) ? ~owner_id_q : owner_id_q;
            end
        end else if (r0_valid && r1_valid) begin
            gnt = 1'b1;
            win = (last_win_q == prio_q && hold_max) ? ~prio_q : prio_q;
        end else if (r0_valid) begin
            gnt = 1'b1;
            win = 1'b0;
        end else if (r1_valid) begin
            gnt = 1'b1;
            win = 1'b1;
        end
        if (reset) begin
            gnt = 1'b0;
        end
    end

    assign sel_addr  = win ? r1_addr  : r0_addr;
    assign sel_wr    = win ? r1_wr    : r0_wr;
    assign sel_be    = win ? r1_be    : r0_be;
    assign sel_wdata = win ? r1_wdata : r0_wdata;
    assign sel_lock  = win ? r1_lock  : r0_lock;

    assign r0_ready      = gnt & ~win;
    assign r1_ready      = gnt & win;
    assign ram_address_a = gnt ? sel_addr : addr_q;
    assign ram_data_a    = gnt ? sel_wdata : data_q;
    assign ram_wren_a    = gnt & sel_wr;
    assign ram_byteena_a = (gnt & sel_wr) ? sel_be : '1;

    // Stage p0 -> p1: arbitration state and read-response tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q      <= 1'b0;
            owner_vld_q <= 1'b0;
            owner_id_q  <= 1'b0;
            last_win_q  <= 1'b0;
            hold_cnt_q  <= 8'd0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= gnt & ~sel_wr;
            if (gnt) begin
                prio_q      <= ~win;
                last_win_q  <= win;
                hold_cnt_q  <= (win == last_win_q) ? sat_inc(hold_cnt_q) : 8'd1;
                owner_vld_q <= sel_lock;
                owner_id_q  <= win;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (gnt) begin
            rsp_owner_p1 <= win;
            addr_q       <= sel_addr;
            data_q       <= sel_wdata;
        end
    end

    assign r0_rsp_valid = vld_p1 & ~rsp_owner_p1 & ~reset;
    assign r1_rsp_valid = vld_p1 & rsp_owner_p1 & ~reset;
    assign r0_rsp_rdata = ram_q_a;
    assign r1_rsp_rdata = ram_q_a;

endmodule

// File: tb/tb_ram_port_a_arbiter.sv
// Bench for ram_port_a_arbiter: behavioural RAM on port A, per-cycle vectors
// with expected grants, and a response scoreboard keyed by due cycle.
module tb_ram_port_a_arbiter;

    localparam int AW = 6;
    localparam int W  = 32;
    localparam int BE = 4;

    logic          clock;
    logic          reset;
    logic          r0_valid, r0_ready, r0_wr, r0_lock, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [BE-1:0] r0_be;
    logic [W-1:0]  r0_wdata, r0_rsp_rdata;
    logic          r1_valid, r1_ready, r1_wr, r1_lock, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [BE-1:0] r1_be;
    logic [W-1:0]  r1_wdata, r1_rsp_rdata;
    logic [AW-1:0] ram_address_a;
    logic          ram_wren_a;
    logic [BE-1:0] ram_byteena_a;
    logic [W-1:0]  ram_data_a;
    logic [W-1:0]  ram_q_a;

    ram_port_a_arbiter #(.DEPTH(64), .WIDTH(32), .MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wr(r0_wr),
        .r0_be(r0_be), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wr(r1_wr),
        .r1_be(r1_be), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a),
        .ram_byteena_a(ram_byteena_a), .ram_data_a(ram_data_a), .ram_q_a(ram_q_a)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Port-A RAM: byte-enabled write, registered read, preloaded with data=addr.
    logic          load;
    logic [W-1:0]  mem [64];
    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 5) ? 32'h11223344 : W'(i);
        end else if (ram_wren_a) begin
            for (int b = 0; b < BE; b++)
                if (ram_byteena_a[b]) mem[ram_address_a][8*b +: 8] <= ram_data_a[8*b +: 8];
        end
        ram_q_a <= mem[ram_address_a];
    end

    typedef struct {
        bit            v;
        bit            wr;
        bit            lk;
        logic [AW-1:0] a;
        logic [BE-1:0] be;
        logic [W-1:0]  d;
    } req_t;

    typedef struct {
        bit   rst;
        req_t r0;
        req_t r1;
        bit   g0;
        bit   g1;
    } vec_t;

    typedef struct {
        bit           port;
        logic [W-1:0] data;
        int           due;
    } rsp_t;

    logic [W-1:0] ref_mem [64];
    rsp_t         exp_q [$];
    int           cyc;
    int           n_tests;
    int           n_fail;

    function automatic req_t no_req();
        req_t r;
        r.v = 0; r.wr = 0; r.lk = 0; r.a = '0; r.be = '0; r.d = '0;
        return r;
    endfunction

    function automatic req_t rd_req(input logic [AW-1:0] a, input bit lk);
        req_t r;
        r.v = 1; r.wr = 0; r.lk = lk; r.a = a; r.be = 4'hF; r.d = '0;
        return r;
    endfunction

    function automatic req_t wr_req(input logic [AW-1:0] a, input logic [BE-1:0] be,
                                    input logic [W-1:0] d, input bit lk);
        req_t r;
        r.v = 1; r.wr = 1; r.lk = lk; r.a = a; r.be = be; r.d = d;
        return r;
    endfunction

    function automatic vec_t mkv(input bit rst, input req_t a, input req_t b,
                                 input bit g0, input bit g1);
        vec_t v;
        v.rst = rst; v.r0 = a; v.r1 = b; v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic granted(input bit port, input req_t r);
        rsp_t e;
        if (r.wr) begin
            for (int b = 0; b < BE; b++)
                if (r.be[b]) ref_mem[r.a][8*b +: 8] = r.d[8*b +: 8];
        end else begin
            e.port = port;
            e.data = ref_mem[r.a];
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic apply(input vec_t v);
        rsp_t e;
        bit   ev0, ev1;
        logic [W-1:0] ed;
        @(posedge clock);
        #1;
        reset    = v.rst;
        r0_valid = v.r0.v; r0_wr = v.r0.wr; r0_lock = v.r0.lk;
        r0_addr  = v.r0.a; r0_be = v.r0.be; r0_wdata = v.r0.d;
        r1_valid = v.r1.v; r1_wr = v.r1.wr; r1_lock = v.r1.lk;
        r1_addr  = v.r1.a; r1_be = v.r1.be; r1_wdata = v.r1.d;
        @(negedge clock);
        cyc++;
        if (v.rst) exp_q.delete();
        ev0 = 0; ev1 = 0; ed = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            ev0 = (e.port == 1'b0);
            ev1 = (e.port == 1'b1);
            ed  = e.data;
        end
        chk("r0_rsp_valid", W'(r0_rsp_valid), W'(ev0));
        chk("r1_rsp_valid", W'(r1_rsp_valid), W'(ev1));
        if (ev0) chk("r0_rsp_rdata", r0_rsp_rdata, ed);
        if (ev1) chk("r1_rsp_rdata", r1_rsp_rdata, ed);
        chk("r0_ready", W'(r0_ready), W'(v.g0));
        chk("r1_ready", W'(r1_ready), W'(v.g1));
        chk("ram_wren_a", W'(ram_wren_a), W'((v.g0 & v.r0.wr) | (v.g1 & v.r1.wr)));
        if (v.g0) begin
            chk("ram_address_a", W'(ram_address_a), W'(v.r0.a));
            chk("ram_byteena_a", W'(ram_byteena_a), W'(v.r0.wr ? v.r0.be : 4'hF));
            granted(1'b0, v.r0);
        end
        if (v.g1) begin
            chk("ram_address_a", W'(ram_address_a), W'(v.r1.a));
            chk("ram_byteena_a", W'(ram_byteena_a), W'(v.r1.wr ? v.r1.be : 4'hF));
            granted(1'b1, v.r1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        vec_t alt [$];
        n_tests = 0; n_fail = 0; cyc = 0;
        load = 1'b1;
        reset = 1'b1;
        r0_valid = 0; r0_wr = 0; r0_lock = 0; r0_addr = '0; r0_be = '0; r0_wdata = '0;
        r1_valid = 0; r1_wr = 0; r1_lock = 0; r1_addr = '0; r1_be = '0; r1_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 5) ? 32'h11223344 : W'(i);

        // Alternation: requesters present the next address only after being granted.
        alt.push_back(mkv(0, rd_req(6'h10, 0), rd_req(6'h20, 0), 1, 0));
        alt.push_back(mkv(0, rd_req(6'h11, 0), rd_req(6'h20, 0), 0, 1));
        alt.push_back(mkv(0, rd_req(6'h11, 0), rd_req(6'h21, 0), 1, 0));
        alt.push_back(mkv(0, rd_req(6'h12, 0), rd_req(6'h21, 0), 0, 1));
        alt.push_back(mkv(0, rd_req(6'h12, 0), rd_req(6'h22, 0), 1, 0));
        alt.push_back(mkv(0, rd_req(6'h13, 0), rd_req(6'h22, 0), 0, 1));
        alt.push_back(mkv(0, rd_req(6'h13, 0), rd_req(6'h23, 0), 1, 0));
        alt.push_back(mkv(0, no_req(),         rd_req(6'h23, 0), 0, 1));
        alt.push_back(mkv(0, no_req(),         no_req(),         0, 0));

        // Reset with both requesters valid
        apply(mkv(1, rd_req(6'h10, 0), rd_req(6'h20, 0), 0, 0));
        load = 1'b0;
        apply(mkv(1, rd_req(6'h10, 0), rd_req(6'h20, 0), 0, 0));
        apply(mkv(1, rd_req(6'h10, 0), rd_req(6'h20, 0), 0, 0));

        for (int i = 0; i < alt.size(); i++) apply(alt[i]);

        // Partial write then read-back from r1
        apply(mkv(0, no_req(), wr_req(6'h05, 4'b0101, 32'hDEADBEEF, 0), 0, 1));
        apply(mkv(0, no_req(), rd_req(6'h05, 0), 0, 1));
        apply(mkv(0, no_req(), no_req(), 0, 0));

        // Locked read-modify-write by r0 while r1 waits
        apply(mkv(0, rd_req(6'h07, 1), rd_req(6'h21, 0), 1, 0));
        apply(mkv(0, wr_req(6'h07, 4'hF, 32'hCAFEF00D, 0), rd_req(6'h21, 0), 1, 0));
        apply(mkv(0, no_req(), rd_req(6'h21, 0), 0, 1));
        apply(mkv(0, no_req(), rd_req(6'h07, 0), 0, 1));
        apply(mkv(0, no_req(), no_req(), 0, 0));

        // Starvation bound: r1 wins on the 5th contended cycle
        for (int i = 0; i < 4; i++)
            apply(mkv(0, rd_req(6'h30, 1), rd_req(6'h31, 0), 1, 0));
        apply(mkv(0, rd_req(6'h30, 1), rd_req(6'h31, 0), 0, 1));
        apply(mkv(0, rd_req(6'h30, 0), no_req(), 1, 0));
        apply(mkv(0, no_req(), no_req(), 0, 0));

        // Idle lock holds the port for 3 cycles
        apply(mkv(0, rd_req(6'h08, 1), no_req(), 1, 0));
        for (int i = 0; i < 3; i++)
            apply(mkv(0, no_req(), rd_req(6'h09, 0), 0, 0));
        apply(mkv(0, rd_req(6'h08, 0), rd_req(6'h09, 0), 1, 0));
        apply(mkv(0, no_req(), rd_req(6'h09, 0), 0, 1));

        // Reset right after a locked read grant: no response, lock dropped
        apply(mkv(0, rd_req(6'h10, 1), no_req(), 1, 0));
        apply(mkv(1, rd_req(6'h10, 1), no_req(), 0, 0));
        apply(mkv(0, no_req(), rd_req(6'h11, 0), 0, 1));
        apply(mkv(0, rd_req(6'h12, 0), rd_req(6'h13, 0), 1, 0));
        apply(mkv(0, no_req(), rd_req(6'h13, 0), 0, 1));
        apply(mkv(0, no_req(), no_req(), 0, 0));

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cyc=%0d got=%0d want=0", cyc, exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
